bit_field_unit: RTL and testbench

BIT_FIELD_UNIT -- requirements
Module: bit_field_unit

---
 rtl/bit_field_unit.sv | 156 +++++++++++++++
 tb/tb_bit_field_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bit_field_unit.sv
// Bit-field unit: sets, clears, toggles or extracts a contiguous field of
// an operand, one bit per clock, with a valid/ready request and result handshake.
module bit_field_unit #(
    parameter int BITS = 32,
    localparam int IDXW = $clog2(BITS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [BITS-1:0] i_argA,
    input  logic [BITS-1:0] i_argB,
    input  logic [IDXW:0]   i_len,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [BITS-1:0] o_result,
    output logic            o_error
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_SET = 2'b00,
        OP_CLR = 2'b01,
        OP_TGL = 2'b10,
        OP_TST = 2'b11
    } op_t;

    localparam logic [IDXW:0] BITS_W  = (IDXW+1)'(BITS);
    localparam logic [IDXW:0] LEN_ONE = (IDXW+1)'(1);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW:0]     len_q, len_d;
    logic [IDXW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0]   a_q, a_d;
    logic [BITS-1:0]   work_q, work_d;
    logic              err_q, err_d;

    logic              idx_high;
    logic [IDXW:0]     field_end;
    logic              illegal;
    logic [IDXW-1:0]   pos;
    logic              last_bit;

    // Request legality: index must fit in IDXW bits, length non-zero,
    // and the field must end at or below the operand MSB.
    always_comb begin
        idx_high  = |i_argB[BITS-1:IDXW];
        field_end = {1'b0, i_argB[IDXW-1:0]} + i_len;
        illegal   = idx_high || (i_len == '0) || (field_end > BITS_W);
    end

    // Bit position handled this cycle and whether it is the final one of the field.
    always_comb begin
        pos      = idx_q + cnt_q;
        last_bit = ({1'b0, cnt_q} == (len_q - LEN_ONE));
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        work_d  = work_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    op_d  = op_t'(i_op);
                    idx_d = i_argB[IDXW-1:0];
                    len_d = i_len;
                    a_d   = i_argA;
                    cnt_d = '0;
                    if (illegal) begin
                        work_d  = i_argA;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        work_d  = (op_t'(i_op) == OP_TST) ? '0 : i_argA;
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end

            BUSY: begin
                case (op_q)
                    OP_SET:  work_d[pos]   = 1'b1;
                    OP_CLR:  work_d[pos]   = 1'b0;
                    OP_TGL:  work_d[pos]   = ~work_q[pos];
                    default: work_d[cnt_q] = a_q[pos];
                endcase
                // Counter parks at len-1 on the final bit so it never
                // steps past the field.
                if (last_bit) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= OP_SET;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            work_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            work_q  <= work_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded directly from registered state.
    always_comb begin
        o_ready  = (state_q == IDLE);
        o_valid  = (state_q == DONE);
        o_result = work_q;
        o_error  = err_q;
    end

endmodule

// File: tb/tb_bit_field_unit.sv
// Directed self-checking bench for bit_field_unit at BITS=32.
module tb_bit_field_unit;

    localparam int BITS = 32;
    localparam int IDXW = 5;

    logic            i_clk;
    logic            i_rst;
    logic            i_valid;
    logic            o_ready;
    logic [1:0]      i_op;
    logic [BITS-1:0] i_argA;
    logic [BITS-1:0] i_argB;
    logic [IDXW:0]   i_len;
    logic            o_valid;
    logic            i_ready;
    logic [BITS-1:0] o_result;
    logic            o_error;

    int n_chk  = 0;
    int n_fail = 0;

    bit_field_unit #(.BITS(BITS)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_argA   (i_argA),
        .i_argB   (i_argB),
        .i_len    (i_len),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_error  (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the result, check it, take it.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] len,
                          input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
        int n;
        @(negedge i_clk);
        i_op = op; i_argA = a; i_argB = b; i_len = len;
        i_valid = 1'b1; i_ready = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk({tag, "_ready_low"}, 64'(o_ready), 64'd0);
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_result"}, 64'(o_result), 64'(exp_res));
        chk({tag, "_error"}, 64'(o_error), 64'(exp_err));
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk({tag, "_idle_ready"}, 64'(o_ready), 64'd1);
        chk({tag, "_idle_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_idle_hold"}, 64'(o_result), 64'(exp_res));
        chk({tag, "_idle_err"}, 64'(o_error), 64'(exp_err));
    endtask

    initial begin
        int n;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_op = 2'b00; i_argA = '0; i_argB = '0; i_len = '0;
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_result", 64'(o_result), 64'd0);
        chk("rst_error", 64'(o_error), 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Legal operations
        run_op("set_5_1",    2'b00, 32'h00000000, 32'd5,  6'd1,  32'h00000020, 1'b0, 1);
        run_op("clr_28_4",   2'b01, 32'hFFFFFFFF, 32'd28, 6'd4,  32'h0FFFFFFF, 1'b0, 4);
        run_op("tgl_4_8",    2'b10, 32'h0000FF00, 32'd4,  6'd8,  32'h0000F0F0, 1'b0, 8);
        run_op("tst_8_8",    2'b11, 32'h12345678, 32'd8,  6'd8,  32'h00000056, 1'b0, 8);
        run_op("set_0_32",   2'b00, 32'h00000000, 32'd0,  6'd32, 32'hFFFFFFFF, 1'b0, 32);
        run_op("tgl_0_32",   2'b10, 32'h0F0F0F0F, 32'd0,  6'd32, 32'hF0F0F0F0, 1'b0, 32);
        run_op("tst_31_1",   2'b11, 32'h80000000, 32'd31, 6'd1,  32'h00000001, 1'b0, 1);

        // Illegal requests
        run_op("ill_idx32",  2'b00, 32'hDEADBEEF, 32'd32,        6'd1, 32'hDEADBEEF, 1'b1, 0);
        run_op("ill_idxmsb", 2'b01, 32'hDEADBEEF, 32'h80000000,  6'd4, 32'hDEADBEEF, 1'b1, 0);
        run_op("ill_30_4",   2'b10, 32'hDEADBEEF, 32'd30,        6'd4, 32'hDEADBEEF, 1'b1, 0);
        run_op("ill_len0",   2'b11, 32'hDEADBEEF, 32'd0,         6'd0, 32'hDEADBEEF, 1'b1, 0);

        // Backpressure: result held while a new request waits
        @(negedge i_clk);
        i_op = 2'b00; i_argA = 32'h0; i_argB = 32'd0; i_len = 6'd2; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("bp_done_valid", 64'(o_valid), 64'd1);
        @(negedge i_clk);
        i_op = 2'b00; i_argA = 32'h0; i_argB = 32'd4; i_len = 6'd1; i_valid = 1'b1; i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk("bp_hold_valid", 64'(o_valid), 64'd1);
            chk("bp_hold_ready", 64'(o_ready), 64'd0);
            chk("bp_hold_result", 64'(o_result), 64'h3);
            chk("bp_hold_error", 64'(o_error), 64'd0);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_take_ready", 64'(o_ready), 64'd1);
        chk("bp_take_valid", 64'(o_valid), 64'd0);
        chk("bp_take_result", 64'(o_result), 64'h3);
        @(negedge i_clk);
        i_ready = 1'b0;
        @(posedge i_clk); #1;
        chk("bp_accept_ready", 64'(o_ready), 64'd0);
        chk("bp_accept_valid", 64'(o_valid), 64'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("bp_next_valid", 64'(o_valid), 64'd1);
        chk("bp_next_result", 64'(o_result), 64'h10);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("bp_next_idle", 64'(o_ready), 64'd1);

        // Reset in the middle of a long operation
        @(negedge i_clk);
        i_op = 2'b00; i_argA = 32'h0; i_argB = 32'd0; i_len = 6'd16; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (5) begin
            @(posedge i_clk); #1;
        end
        chk("mid_partial", 64'(o_result), 64'h1F);
        chk("mid_valid", 64'(o_valid), 64'd0);
        #1;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_result", 64'(o_result), 64'd0);
        chk("mid_rst_error", 64'(o_error), 64'd0);
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_op = 2'b00; i_argA = 32'h0; i_argB = 32'd3; i_len = 6'd1; i_valid = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("rst_noaccept_ready", 64'(o_ready), 64'd1);
        chk("rst_noaccept_result", 64'(o_result), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0; i_valid = 1'b0;
        n = 0;
        repeat (20) begin
            @(posedge i_clk); #1;
            if (o_valid) n++;
        end
        chk("rst_no_valid_pulse", 64'(n), 64'd0);

        run_op("tst_16_16", 2'b11, 32'hABCD1234, 32'd16, 6'd16, 32'h0000ABCD, 1'b0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
